// File: rtl/comm_master_pkg.sv
// comm_master_pkg: shared constants for the host-side UART command master.
//   - Send-FSM state encodings (IDLE, TX_HIGH, TX_LOW, DONE)
//   - Receiver state encodings
//   - UART 8N1 frame length and a helper that builds a frame from a byte
package comm_master_pkg;

  // Send FSM states
  localparam logic [1:0] SND_IDLE    = 2'd0;
  localparam logic [1:0] SND_TX_HIGH = 2'd1;
  localparam logic [1:0] SND_TX_LOW  = 2'd2;
  localparam logic [1:0] SND_DONE    = 2'd3;

  // Receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // 1 start + 8 data + 1 stop
  localparam int         FRAME_BITS = 10;
  localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);

  // Frame as it leaves the wire, index 0 first: start(0), data LSB first, stop(1)
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/comm_uart_tx_core.sv
// comm_uart_tx_core: serializes one byte as an 8N1 UART frame.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   data[7:0]  - byte to send, sampled when start is accepted
//   start      - accepted when idle, or in the last cycle of the current
//                frame (back-to-back frames with no idle gap)
//   tx         - registered serial line, idle high
//   byte_done  - high during the final cycle of the stop bit
module comm_uart_tx_core
  import comm_master_pkg::*;
#(
  parameter int BAUD_DIV = 108
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       byte_done
);

  localparam int              CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic                  busy;
  logic [FRAME_BITS-1:0] shift;
  logic [3:0]            bit_cnt;
  logic [CNT_W-1:0]      baud_cnt;

  assign byte_done = busy && (baud_cnt == BAUD_LAST) && (bit_cnt == FRAME_LAST);

  // NOTE: every register here is written with <= so all state updates see the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      tx       <= 1'b1;
      shift    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (start && (!busy || byte_done)) begin
      shift    <= frame_of(data);
      tx       <= 1'b0;            // start bit goes out immediately
      bit_cnt  <= '0;
      baud_cnt <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == FRAME_LAST) begin
          busy <= 1'b0;
          tx   <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shift   <= {1'b1, shift[FRAME_BITS-1:1]};
          tx      <= shift[1];
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/comm_master.sv
// comm_master: host-side UART command master (host model for the analyzer core).
// Sends a 16-bit command as two back-to-back 8N1 bytes (high byte first) and
// independently receives 8N1 response bytes.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   RX          - serial input from the core (asynchronous, idle high)
//   TX          - serial output to the core (idle high)
//   cmd[15:0]   - command word, captured when snd_cmd is accepted
//   snd_cmd     - single-cycle send request (ignored while a send is active)
//   cmd_cmplt   - high once both bytes have gone out; held until next send
//   resp[7:0]   - last received byte
//   resp_cmplt  - new unacknowledged byte in resp
//   clr_rdy     - clears resp_cmplt
//   frm_err     - (only with COMM_MASTER_FRAME_ERR_EN) stop bit sampled low
// Build option: define COMM_MASTER_FRAME_ERR_EN to add frame-error reporting.
module comm_master
  import comm_master_pkg::*;
#(
  parameter int BAUD_DIV = 108
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_cmplt,
  output logic [7:0]  resp,
  output logic        resp_cmplt,
  input  logic        clr_rdy
`ifdef COMM_MASTER_FRAME_ERR_EN
  ,
  output logic        frm_err
`endif
);

  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  // ---------------- Send path ----------------
  logic [1:0] snd_state;
  logic [7:0] cmd_lo;
  logic       cmd_accept;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  assign cmd_accept = (snd_state == SND_IDLE) && snd_cmd;

  // NOTE: defaults first so every path assigns every output; otherwise the
  // tool would infer latches for the cases that leave them untouched.
  always_comb begin
    tx_start = 1'b0;
    tx_data  = cmd[15:8];
    case (snd_state)
      SND_IDLE:    tx_start = snd_cmd;
      SND_TX_HIGH: begin
        tx_start = tx_done;         // chain low byte into the stop-bit end
        tx_data  = cmd_lo;
      end
      default:     tx_start = 1'b0;
    endcase
  end

  comm_uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx_core (
    .clk       (clk),
    .rst       (rst),
    .data      (tx_data),
    .start     (tx_start),
    .tx        (TX),
    .byte_done (tx_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      snd_state <= SND_IDLE;
      cmd_lo    <= '0;
      cmd_cmplt <= 1'b0;
    end else begin
      case (snd_state)
        SND_IDLE: if (snd_cmd) begin
          cmd_lo    <= cmd[7:0];
          cmd_cmplt <= 1'b0;
          snd_state <= SND_TX_HIGH;
        end
        SND_TX_HIGH: if (tx_done) snd_state <= SND_TX_LOW;
        SND_TX_LOW:  if (tx_done) snd_state <= SND_DONE;
        SND_DONE: begin
          cmd_cmplt <= 1'b1;
          snd_state <= SND_IDLE;
        end
        default: snd_state <= SND_IDLE;
      endcase
    end
  end

  // ---------------- Receive path ----------------
  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_set;

  // Stop-bit sample point: byte is complete
  assign rx_set = (rx_state == RX_STOP) && (rx_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      resp     <= '0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_sync) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // High at mid start bit means a glitch, not a frame
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_set) begin
            rx_cnt   <= '0;
            resp     <= rx_shift;
            rx_state <= RX_IDLE;   // re-arm at mid stop bit
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Set has priority over clear
  always_ff @(posedge clk) begin
    if (rst)                         resp_cmplt <= 1'b0;
    else if (rx_set)                 resp_cmplt <= 1'b1;
    else if (clr_rdy || cmd_accept)  resp_cmplt <= 1'b0;
  end

`ifdef COMM_MASTER_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)                         frm_err <= 1'b0;
    else if (rx_set && !rx_sync)     frm_err <= 1'b1;
    else if (clr_rdy || cmd_accept)  frm_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_comm_master.sv
// tb_comm_master: directed self-checking bench for comm_master (default build).
module tb_comm_master;

  localparam int BD = 108;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        cmd_cmplt;
  logic [7:0]  resp;
  logic        resp_cmplt;
  logic        clr_rdy = 1'b0;
`ifdef COMM_MASTER_FRAME_ERR_EN
  logic        frm_err;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  comm_master #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .snd_cmd    (snd_cmd),
    .cmd_cmplt  (cmd_cmplt),
    .resp       (resp),
    .resp_cmplt (resp_cmplt),
    .clr_rdy    (clr_rdy)
`ifdef COMM_MASTER_FRAME_ERR_EN
    ,
    .frm_err    (frm_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Wire image of a command, index 0 first: high byte frame then low byte frame
  function automatic logic [19:0] wire_bits(input logic [15:0] c);
    return {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
  endfunction

  // Send c; optionally fire a second snd_cmd with c2 mid-transfer.
  task automatic send_cmd(input string tag, input logic [15:0] c,
                          input bit inject, input logic [15:0] c2);
    logic [19:0] seen;
    int          done_at;
    seen    = '0;
    done_at = -1;
    cmd     = c;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    check({tag, "_start_bit"}, 32'(TX), 32'd0);
    check({tag, "_cmplt_clr"}, 32'(cmd_cmplt), 32'd0);
    for (int n = 1; n <= 20*BD + 20; n++) begin
      tick();
      if (inject && n == 700) begin
        cmd     = c2;
        snd_cmd = 1'b1;
      end
      if (inject && n == 701) snd_cmd = 1'b0;
      if ((n % BD) == BD/2 && (n / BD) < 20) seen[n/BD] = TX;
      if (cmd_cmplt && done_at < 0) done_at = n;
    end
    check({tag, "_frame"}, 32'(seen), 32'(wire_bits(c)));
    check({tag, "_latency"}, 32'(done_at), 32'(20*BD + 1));
    check({tag, "_cmplt_held"}, 32'(cmd_cmplt), 32'd1);
    check({tag, "_tx_idle"}, 32'(TX), 32'd1);
  endtask

  task automatic drive_rx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BD) tick();
    end
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_cmd_cmplt", 32'(cmd_cmplt), 32'd0);
    check("rst_resp_cmplt", 32'(resp_cmplt), 32'd0);
    check("rst_resp", 32'(resp), 32'h00);
    rst = 1'b0;
    repeat (5) tick();

    // Send, then busy-ignore with a conflicting request mid-frame
    send_cmd("send_a55a", 16'hA55A, 1'b0, 16'h0000);
    repeat (10) tick();
    send_cmd("busy_a55a", 16'hA55A, 1'b1, 16'h1234);
    repeat (10) tick();

    // Receive 3C and acknowledge
    drive_rx(8'h3C);
    check("rx_3c_resp", 32'(resp), 32'h3C);
    check("rx_3c_flag", 32'(resp_cmplt), 32'd1);
    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;
    check("clr_flag", 32'(resp_cmplt), 32'd0);
    check("clr_resp_kept", 32'(resp), 32'h3C);

    // Two bytes without acknowledge: second overwrites, flag stays set
    drive_rx(8'h5A);
    drive_rx(8'h81);
    check("ovw_resp", 32'(resp), 32'h81);
    check("ovw_flag", 32'(resp_cmplt), 32'd1);
    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;

    // Short low glitch: false start, nothing received
    RX = 1'b0;
    repeat (20) tick();
    RX = 1'b1;
    repeat (3*BD) tick();
    check("glitch_flag", 32'(resp_cmplt), 32'd0);
    check("glitch_resp", 32'(resp), 32'h81);

    // Receiver re-armed after glitch
    drive_rx(8'hC3);
    check("rearm_resp", 32'(resp), 32'hC3);
    check("rearm_flag", 32'(resp_cmplt), 32'd1);

    // Accepted snd_cmd clears resp_cmplt; reset during 5th data bit aborts
    cmd     = 16'h0000;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    check("snd_clears_resp", 32'(resp_cmplt), 32'd0);
    repeat (5*BD + 50) tick();
    check("abort_mid_frame", 32'(TX), 32'd0);
    rst = 1'b1;
    tick();
    check("abort_tx", 32'(TX), 32'd1);
    check("abort_cmplt", 32'(cmd_cmplt), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    send_cmd("after_abort", 16'h0001, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
